data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Data-memory slave at the far end of the MEM-stage request interface. It accepts the request fields held in the EX/MEM register (enable, read/write, size, address, store data) and performs big-endian byte/halfword/word accesses with a configurable number of wait states. It stalls the pipeline through `busy` until the access completes. Read data is returned sign- or zero-extended, ready for the MEM/WB register.

## Interface
- `ADDR_W`, default 9: byte-address width of the internal array (2^ADDR_W bytes); upper address bits are ignored.
- `WAIT_STATES`, default 2: extra cycles per access, range 0–15.

- `clk`  in  1  single clock, rising edge.
- `R`  in  1  reset, asynchronous, active-high.
- `E`  in  1  request valid; held stable by the requester while `busy`=1.
- `rw`  in  1  0 = read (load), 1 = write (store).
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `se`  in  1  sign-extend read data (LDSB/LDSH); ignored on writes.
- `addr`  in  32  byte address (ALU result).
- `din`  in  32  store data, right-justified.
- `dout`  out  32  registered load data; reset 0.
- `busy`  out  1  combinational stall request to the pipeline; reset 0.
- `done`  out  1  registered one-cycle completion pulse; reset 0.
- `err`  out  1  registered misalignment or illegal-size pulse, coincident with `done`; reset 0.

## Operation
- FSM states:
  - IDLE:
    - `E`=0: stay.
    - `E`=1 with a bad request: go to DONE with `err`=1.
    - `E`=1 otherwise: latch the request; go to WAIT, or to DONE if `WAIT_STATES`=0.
  - WAIT: the counter loads `WAIT_STATES`−1 on entry and decrements each cycle; at 0 go to DONE.
  - DONE: go to IDLE unconditionally.
- Bad request:
  - `size`=11.
  - `size`=01 with `addr[0]`=1.
  - `size`=10 with `addr[1:0]`≠0.
  - A bad request causes no array access, and `dout`=0.
- `busy` = (IDLE & `E`) | WAIT. It is 0 in DONE, so the requester advances on the edge that ends DONE. A new request is therefore first seen in IDLE.
- The access commits on the edge entering DONE, using the latched request (not live inputs).
- Big-endian layout: byte `addr` maps to bits [31:24] of the aligned word.
  - Byte write stores `din[7:0]`.
  - Halfword write stores `din[15:0]` at `addr` and `addr`+1.
  - Word write stores all 4 bytes.
- Reads are right-justified into `dout`:
  - `se`=1 replicates bit 7 (byte) or bit 15 (halfword) into the upper bits.
  - `se`=0 zero-fills the upper bits.
  - Word reads ignore `se`.
- During a write, `dout` holds its previous value.
- Address wrap: only `addr[ADDR_W-1:0]` is used.

## Timing
- Latency: request seen in IDLE at cycle 0; `done`=1 in cycle 1+`WAIT_STATES`; `busy`=1 during cycles 0..`WAIT_STATES`.
- Bad request: `done`=`err`=1 in cycle 1 regardless of `WAIT_STATES`; `busy`=1 in cycle 0 only.
- Back-to-back requests: minimum period `WAIT_STATES`+2 cycles.
- `R` asserted at any time:
  - Immediately forces IDLE, clears the counter, and drives `dout`, `done`, `err` to 0.
  - A pending write is discarded (no partial byte lanes written).
  - Array contents are not reset.
- `R` deasserted with `E`=1: the request is accepted in the first cycle after release.
- Changes to `E`/`rw`/`addr` during WAIT have no effect (the latched copy is used).

## Configuration
- `DMEM_PRELOAD_EN` defined: the array is initialised at time 0 from `dmem_init.hex` via `$readmemh`, one byte per line, starting at address 0.
- `DMEM_PRELOAD_EN` undefined: array contents are unknown until written; no file access.

## Test plan
- `WAIT_STATES`=2, word write 0xDEADBEEF to 0x10 → `busy`=1 in cycles 0–2, `done`=1 in cycle 3; a word read from 0x10 returns 0xDEADBEEF.
- Byte read at 0x10 with `se`=1 → `dout`=0xFFFFFFDE; halfword read at 0x12 with `se`=0 → 0x0000BEEF; byte read at 0x13 with `se`=1 → 0xFFFFFFEF.
- Byte write of 0x55 to 0x11, then word read at 0x10 → 0xDE55BEEF; halfword write of 0x1234 to 0x12, then word read → 0xDE551234.
- Word access at 0x13, or `size`=11 → `done`=`err`=1 in cycle 1; memory unchanged; `dout`=0.
- Word write of 0xCAFEF00D to 0x20 with `R` pulsed during WAIT → all outputs 0 and FSM in IDLE; a later word read of 0x20 returns the old contents.
- `WAIT_STATES`=0, two back-to-back reads → `busy` is high for 1 cycle and `done` follows 1 cycle later for each; the second read's `done` falls 2 cycles after the first's.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response bundle between the MEM stage and the data memory.
// Latency: none, wires only.
// Backpressure: slave raises busy; master holds E/rw/size/se/addr/din stable while busy is high.
interface data_memory_responder_if;
  logic        E;
  logic        rw;
  logic [1:0]  size;
  logic        se;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output E, rw, size, se, addr, din,
    input  dout, busy, done, err
  );

  modport slave (
    input  E, rw, size, se, addr, din,
    output dout, busy, done, err
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: big-endian byte/halfword/word data memory behind the MEM-stage request bus.
// Latency: done one cycle after acceptance plus WAIT_STATES; bad requests finish in one cycle with err.
// Backpressure: combinational busy while a request sits in IDLE or WAIT; requester holds its inputs.
module data_memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    R,
  data_memory_responder_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;

  // Latched copy of the request; WAIT ignores the live bus.
  logic                r_rw;
  logic [1:0]          r_size;
  logic                r_se;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_din;

  logic [31:0]         r_dout;
  logic                r_done;
  logic                r_err;

  logic [7:0]          r_mem [DEPTH];

  logic                w_bad;
  logic                w_take;
  logic                w_commit;
  logic                w_fail;
  logic                w_live;
  logic                w_a_rw;
  logic [1:0]          w_a_size;
  logic                w_a_se;
  logic [ADDR_W-1:0]   w_a_addr;
  logic [31:0]         w_a_din;
  logic [ADDR_W-1:0]   w_addr1;
  logic [ADDR_W-1:0]   w_addr2;
  logic [ADDR_W-1:0]   w_addr3;
  logic [7:0]          w_b0;
  logic [7:0]          w_b1;
  logic [7:0]          w_b2;
  logic [7:0]          w_b3;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // Address bits above the array size are intentionally dropped (address wrap).
  assign w_unused = ^bus.addr[31:ADDR_W];

  // Illegal size or misaligned halfword/word access.
  assign w_bad = (bus.size == 2'b11)
               | ((bus.size == 2'b01) & bus.addr[0])
               | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));

  // With zero wait states the commit edge is the acceptance edge, so the live bus is used there.
  assign w_live   = (r_state == ST_IDLE);
  assign w_a_rw   = w_live ? bus.rw                 : r_rw;
  assign w_a_size = w_live ? bus.size               : r_size;
  assign w_a_se   = w_live ? bus.se                 : r_se;
  assign w_a_addr = w_live ? bus.addr[ADDR_W-1:0]   : r_addr;
  assign w_a_din  = w_live ? bus.din                : r_din;

  assign w_addr1 = w_a_addr + ADDR_W'(1);
  assign w_addr2 = w_a_addr + ADDR_W'(2);
  assign w_addr3 = w_a_addr + ADDR_W'(3);

  assign w_b0 = r_mem[w_a_addr];
  assign w_b1 = r_mem[w_addr1];
  assign w_b2 = r_mem[w_addr2];
  assign w_b3 = r_mem[w_addr3];

  // Right-justify big-endian read data with optional sign extension.
  always_comb begin
    w_rdata = 32'd0;
    case (w_a_size)
      2'b00:   w_rdata = w_a_se ? {{24{w_b0[7]}}, w_b0} : {24'd0, w_b0};
      2'b01:   w_rdata = w_a_se ? {{16{w_b0[7]}}, w_b0, w_b1} : {16'd0, w_b0, w_b1};
      default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // Next-state and strobe decode; commit marks the edge entering DONE for a good request.
  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_commit = 1'b0;
    w_fail   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.E) begin
          if (w_bad) begin
            w_fail = 1'b1;
            w_next = ST_DONE;
          end else begin
            w_take   = 1'b1;
            w_commit = (WAIT_STATES == 0);
            w_next   = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Low in DONE so the requester advances on the edge that ends DONE.
  assign bus.busy = ((r_state == ST_IDLE) & bus.E) | (r_state == ST_WAIT);
  assign bus.dout = r_dout;
  assign bus.done = r_done;
  assign bus.err  = r_err;

  // State register.
  always_ff @(posedge clk or posedge R) begin
    if (R) r_state <= ST_IDLE;
    else   r_state <= w_next;
  end

  // Wait-state counter: loaded on acceptance, counts down to zero in WAIT.
  always_ff @(posedge clk or posedge R) begin
    if (R)                                       r_cnt <= 4'd0;
    else if (w_take)                             r_cnt <= CNT_INIT;
    else if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Capture the request when it is accepted.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_rw   <= 1'b0;
      r_size <= 2'b00;
      r_se   <= 1'b0;
      r_addr <= '0;
      r_din  <= 32'd0;
    end else if (w_take) begin
      r_rw   <= bus.rw;
      r_size <= bus.size;
      r_se   <= bus.se;
      r_addr <= bus.addr[ADDR_W-1:0];
      r_din  <= bus.din;
    end
  end

  // Completion pulses and load data; writes leave dout untouched, bad requests clear it.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_dout <= 32'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (w_next == ST_DONE);
      r_err  <= w_fail;
      if (w_fail)                   r_dout <= 32'd0;
      else if (w_commit && !w_a_rw) r_dout <= w_rdata;
    end
  end

  // Byte-lane writes; gated by reset so a write pending under reset is dropped whole.
  always_ff @(posedge clk) begin
    if (!R && w_commit && w_a_rw) begin
      case (w_a_size)
        2'b00: r_mem[w_a_addr] <= w_a_din[7:0];
        2'b01: begin
          r_mem[w_a_addr] <= w_a_din[15:8];
          r_mem[w_addr1]  <= w_a_din[7:0];
        end
        default: begin
          r_mem[w_a_addr] <= w_a_din[31:24];
          r_mem[w_addr1]  <= w_a_din[23:16];
          r_mem[w_addr2]  <= w_a_din[15:8];
          r_mem[w_addr3]  <= w_a_din[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized and directed checks of data_memory_responder against a byte-array model.
// Two instances: WAIT_STATES=2 for the main traffic, WAIT_STATES=0 for back-to-back timing.
module tb_data_memory_responder;
  localparam int AW  = 9;
  localparam int WS  = 2;
  localparam int MSZ = 1 << AW;

  logic clk = 1'b0;
  logic R;
  always #5 clk = ~clk;

  data_memory_responder_if bus_a ();
  data_memory_responder_if bus_b ();

  data_memory_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut_a (.clk(clk), .R(R), .bus(bus_a.slave));
  data_memory_responder #(.ADDR_W(AW), .WAIT_STATES(0))  dut_b (.clk(clk), .R(R), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [MSZ];
  logic [31:0] m_dout;
  logic [31:0] last_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: memory is a flat byte array, most significant byte at the lowest address.
  task automatic model_apply(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] d, output bit bad);
    int     n;
    int     base;
    longint v;
    bad = is_bad(sz, a);
    if (bad) begin
      m_dout = 32'd0;
      return;
    end
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a % MSZ);
    if (w) begin
      for (int i = 0; i < n; i++)
        ref_mem[(base + i) % MSZ] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v * 256 + longint'(ref_mem[(base + i) % MSZ]);
      if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
      m_dout = 32'(v);
    end
  endtask

  task automatic drive_a(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
    bus_a.E    = 1'b1;
    bus_a.rw   = w;
    bus_a.size = sz;
    bus_a.se   = sx;
    bus_a.addr = a;
    bus_a.din  = d;
  endtask

  // Follows one request on dut_a from cycle 0; optionally scrambles the bus while waiting.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, input string tag);
    bit          bad;
    int          exp_lat;
    int          busy_n;
    int          lat;
    bit          seen;
    logic        err_o;
    logic [31:0] dout_o;
    model_apply(w, sz, sx, a, d, bad);
    exp_lat = bad ? 1 : 1 + WS;
    busy_n  = 0;
    lat     = -1;
    seen    = 1'b0;
    err_o   = 1'b0;
    dout_o  = 32'd0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus_a.busy) busy_n++;
      if (bus_a.done) begin
        seen   = 1'b1;
        lat    = c;
        err_o  = bus_a.err;
        dout_o = bus_a.dout;
        bus_a.E = 1'b0;
      end else if (scramble && c >= 1) begin
        bus_a.E    = 1'($urandom_range(0, 1));
        bus_a.rw   = 1'($urandom_range(0, 1));
        bus_a.size = 2'($urandom_range(0, 3));
        bus_a.se   = 1'($urandom_range(0, 1));
        bus_a.addr = $urandom;
        bus_a.din  = $urandom;
      end
    end
    bus_a.E = 1'b0;
    last_dout = dout_o;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, busy_n, bad ? 1 : WS + 1);
    chk({tag, " err"}, err_o, bad);
    chk({tag, " dout"}, dout_o, m_dout);
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input string tag);
    @(posedge clk);
    #1;
    drive_a(w, sz, sx, a, d);
    run_req(w, sz, sx, a, d, scramble, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [6:0]    b_busy_exp;
    bit [6:0]    b_done_exp;
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    int          pick;

    R = 1'b1;
    bus_a.E = 1'b0; bus_a.rw = 1'b0; bus_a.size = 2'b00; bus_a.se = 1'b0; bus_a.addr = 32'd0; bus_a.din = 32'd0;
    bus_b.E = 1'b0; bus_b.rw = 1'b0; bus_b.size = 2'b00; bus_b.se = 1'b0; bus_b.addr = 32'd0; bus_b.din = 32'd0;
    m_dout = 32'd0;
    last_dout = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset dout", bus_a.dout, 32'd0);
    chk("reset busy", bus_a.busy, 1'b0);
    chk("reset done", bus_a.done, 1'b0);
    chk("reset err",  bus_a.err,  1'b0);
    chk("reset b done", bus_b.done, 1'b0);
    R = 1'b0;

    // Zero wait states: write then two loads, all back to back.
    b_busy_exp = 7'b0010101;
    b_done_exp = 7'b0101010;
    @(posedge clk);
    #1;
    bus_b.E = 1'b1; bus_b.rw = 1'b1; bus_b.size = 2'b10; bus_b.se = 1'b0;
    bus_b.addr = 32'h40; bus_b.din = 32'h1234A678;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("ws0 busy c%0d", c), bus_b.busy, b_busy_exp[c]);
      chk($sformatf("ws0 done c%0d", c), bus_b.done, b_done_exp[c]);
      if (c == 3) chk("ws0 byte read", bus_b.dout, 32'h00000012);
      if (c == 5) chk("ws0 half read", bus_b.dout, 32'hFFFFA678);
      if (c == 1) begin
        bus_b.rw = 1'b0; bus_b.size = 2'b00; bus_b.se = 1'b0; bus_b.addr = 32'h40;
      end
      if (c == 3) begin
        bus_b.rw = 1'b0; bus_b.size = 2'b01; bus_b.se = 1'b1; bus_b.addr = 32'h42;
      end
      if (c == 5) bus_b.E = 1'b0;
    end

    // Give every byte a defined value.
    for (int i = 0; i < MSZ / 4; i++)
      access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0, "fill");

    // Directed big-endian cases.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "wr word 10");
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "rd word 10");
    chk("word 10 value", last_dout, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, "rd sbyte 10");
    chk("sbyte 10 value", last_dout, 32'hFFFFFFDE);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, "rd uhalf 12");
    chk("uhalf 12 value", last_dout, 32'h0000BEEF);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, "rd sbyte 13");
    chk("sbyte 13 value", last_dout, 32'hFFFFFFEF);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, 1'b0, "wr byte 11");
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "rd word 10b");
    chk("word after byte wr", last_dout, 32'hDE55BEEF);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h77771234, 1'b1, "wr half 12");
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "rd word 10c");
    chk("word after half wr", last_dout, 32'hDE551234);
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, "misaligned word");
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 1'b0, "illegal size");
    access(1'b1, 2'b10, 1'b0, 32'h11, 32'h01020304, 1'b0, "misaligned wr");
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "rd word 10d");
    chk("word after bad reqs", last_dout, 32'hDE551234);

    // Reset during WAIT drops the pending write.
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, "rd before rst");
    @(posedge clk);
    #1;
    drive_a(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    chk("busy in wait", bus_a.busy, 1'b1);
    R = 1'b1;
    bus_a.E = 1'b0;
    #1;
    chk("rst busy", bus_a.busy, 1'b0);
    chk("rst dout", bus_a.dout, 32'd0);
    chk("rst done", bus_a.done, 1'b0);
    chk("rst err",  bus_a.err,  1'b0);
    m_dout = 32'd0;
    @(negedge clk);
    chk("rst held done", bus_a.done, 1'b0);
    // Request present while reset releases: accepted in the first cycle afterwards.
    drive_a(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    R = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "rd after rst");

    // Random traffic, including wrapped addresses and bad requests.
    for (int k = 0; k < 300; k++) begin
      w    = 1'($urandom_range(0, 1));
      sx   = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      sz   = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
      a    = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      access(w, sz, sx, a, $urandom, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
